// File: rtl/prefix_adder_bist_pkg.sv
// Shared types and helpers for the prefix-adder stimulus checker: FSM states, xorshift64
// generator, default seed and the corner-vector ROM used when STIM_CORNER_EN is defined.
package prefix_adder_bist_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} bist_state_e;

    localparam logic [63:0] DefaultSeed = 64'h9E37_79B9_7F4A_7C15;
    localparam logic [63:0] CornerOnes  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] Corner0101  = 64'h5555_5555_5555_5555;
    localparam logic [63:0] Corner1010  = 64'hAAAA_AAAA_AAAA_AAAA;

    function automatic logic [63:0] xorshift64_next(input logic [63:0] s);
        logic [63:0] x;
        x = s ^ (s << 13);
        x = x ^ (x >> 7);
        x = x ^ (x << 17);
        return x;
    endfunction

    function automatic logic [63:0] seed_fix(input logic [63:0] s);
        return (s == 64'd0) ? DefaultSeed : s;
    endfunction

    function automatic logic [63:0] corner_a(input logic [1:0] i);
        unique case (i)
            2'd0:    return 64'd0;
            2'd1:    return CornerOnes;
            2'd2:    return CornerOnes;
            default: return Corner0101;
        endcase
    endfunction

    function automatic logic [63:0] corner_b(input logic [1:0] i);
        unique case (i)
            2'd0:    return 64'd0;
            2'd1:    return 64'd1;
            2'd2:    return CornerOnes;
            default: return Corner1010;
        endcase
    endfunction

endpackage

// File: rtl/prefix_adder_exp_delay.sv
// Shift line carrying {valid, vector index, expected result} alongside the DUT pipeline.
module prefix_adder_exp_delay #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned EXP_W = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid_i,
    input  logic [31:0]      push_idx_i,
    input  logic [EXP_W-1:0] push_exp_i,
    output logic             out_valid_o,
    output logic [31:0]      out_idx_o,
    output logic [EXP_W-1:0] out_exp_o,
    output logic             any_valid_o
);

    logic [DEPTH-1:0] valid_q;
    logic [31:0]      idx_q [DEPTH];
    logic [EXP_W-1:0] exp_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx_q[i] <= '0;
                exp_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= push_valid_i;
            idx_q[0]   <= push_idx_i;
            exp_q[0]   <= push_exp_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
                exp_q[i]   <= exp_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_idx_o   = idx_q[DEPTH-1];
    assign out_exp_o   = exp_q[DEPTH-1];
    assign any_valid_o = |valid_q;

endmodule

// File: rtl/prefix_adder_stim_checker.sv
// On-chip BIST traffic end for registered prefix-adder wrappers.
// Define STIM_CORNER_EN to prepend four fixed corner vectors to each run.
module prefix_adder_stim_checker
    import prefix_adder_bist_pkg::*;
#(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned NUM_VECTORS = 1024,
    parameter logic [63:0] SEED        = 64'h9E37_79B9_7F4A_7C15,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      first_fail_idx,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout
);

`ifdef STIM_CORNER_EN
    localparam int unsigned NumCorner = 4;
`else
    localparam int unsigned NumCorner = 0;
`endif
    localparam int unsigned Total   = NUM_VECTORS + NumCorner;
    localparam int unsigned ExpW    = WIDTH + 1;
    localparam logic [63:0] SeedEff = seed_fix(SEED);

    bist_state_e      state_q, state_d;
    logic [63:0]      lfsr_q, lfsr_d;
    logic [31:0]      idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [31:0]      first_q, first_d;

    logic             issue, launch, use_corner;
    logic [31:0]      issue_idx;
    logic [63:0]      src_s, raw_a, raw_b;
    logic [ExpW-1:0]  push_exp, out_exp;
    logic [31:0]      out_idx;
    logic             out_valid, line_busy, mismatch;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        issue     = 1'b0;
        launch    = 1'b0;
        issue_idx = idx_q;
        src_s     = lfsr_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    launch    = 1'b1;
                    issue     = 1'b1;
                    issue_idx = '0;
                    src_s     = SeedEff;
                    idx_d     = 32'd1;
                    state_d   = (Total == 1) ? StDrain : StRun;
                end
            end
            StRun: begin
                issue = 1'b1;
                idx_d = idx_q + 32'd1;
                if (idx_q == 32'(Total - 1)) state_d = StDrain;
            end
            StDrain: begin
                if (!line_busy) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // Corner vectors do not consume generator steps, so random vector k always uses step k.
    always_comb begin
`ifdef STIM_CORNER_EN
        use_corner = (issue_idx < 32'd4);
`else
        use_corner = 1'b0;
`endif
        raw_a = src_s;
        raw_b = {src_s[31:0], src_s[63:32]};
`ifdef STIM_CORNER_EN
        if (use_corner) begin
            raw_a = corner_a(issue_idx[1:0]);
            raw_b = corner_b(issue_idx[1:0]);
        end
`endif
        lfsr_d = lfsr_q;
        a_d    = a_q;
        b_d    = b_q;
        if (issue) begin
            lfsr_d = use_corner ? src_s : xorshift64_next(src_s);
            a_d    = raw_a[WIDTH-1:0];
            b_d    = raw_b[WIDTH-1:0];
        end
        push_exp = {1'b0, a_d} + {1'b0, b_d};
    end

    assign mismatch = out_valid && ({cout, sum} != out_exp);

    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        if (launch) begin
            err_d   = '0;
            first_d = '1;
        end else if (mismatch) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (first_q == '1) first_d = out_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lfsr_q  <= SeedEff;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= '0;
            first_q <= '1;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    prefix_adder_exp_delay #(
        .DEPTH (LATENCY + 1),
        .EXP_W (ExpW)
    ) u_exp_delay (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (issue),
        .push_idx_i   (issue_idx),
        .push_exp_i   (push_exp),
        .out_valid_o  (out_valid),
        .out_idx_o    (out_idx),
        .out_exp_o    (out_exp),
        .any_valid_o  (line_busy)
    );

    assign busy           = (state_q == StRun) || (state_q == StDrain);
    assign done           = (state_q == StDone);
    assign pass           = done && (err_q == '0);
    assign err_count      = err_q;
    assign first_fail_idx = first_q;
    assign a              = a_q;
    assign b              = b_q;

endmodule

// File: tb/tb_prefix_adder_stim_checker.sv
// Bench for prefix_adder_stim_checker: drives it against a behavioural adder wrapper with
// selectable faults and checks results against a vector-list reference model.
module tb_prefix_adder_stim_checker;

    localparam int W = 64;
    localparam int L = 2;
    localparam int N = 16;
`ifdef STIM_CORNER_EN
    localparam int NC = 4;
`else
    localparam int NC = 0;
`endif
    localparam int T = N + NC;
    localparam logic [63:0] SEED = 64'h9E37_79B9_7F4A_7C15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass, cout;
    logic [15:0]   err_count;
    logic [31:0]   first_fail_idx;
    logic [W-1:0]  a, b, sum;

    always #5 clk = ~clk;

    prefix_adder_stim_checker #(
        .WIDTH       (W),
        .LATENCY     (L),
        .NUM_VECTORS (N),
        .SEED        (SEED),
        .ERR_W       (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_idx (first_fail_idx),
        .a              (a),
        .b              (b),
        .sum            (sum),
        .cout           (cout)
    );

    // Adder wrapper model: mode 0 ideal, 1 result bit stuck at 0, 2 one extra stage.
    int           mode = 0;
    int           bitk = 0;
    logic [63:0]  ra, rb;
    logic [64:0]  s2, s3, sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra <= '0;
            rb <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            ra <= a;
            rb <= b;
            s2 <= {1'b0, ra} + {1'b0, rb};
            s3 <= s2;
        end
    end

    always_comb begin
        sel = (mode == 2) ? s3 : s2;
        if (mode == 1) sel[bitk] = 1'b0;
    end
    assign {cout, sum} = sel;

    // Reference vector list
    logic [63:0] va [T];
    logic [63:0] vb [T];
    logic [64:0] vs [T];

    int n_cmp = 0;
    int n_fail = 0;

    function automatic logic [63:0] xs_step(input logic [63:0] s);
        logic [63:0] x;
        x = s ^ (s << 13);
        x = x ^ (x >> 7);
        x = x ^ (x << 17);
        return x;
    endfunction

    task automatic build_model();
        logic [63:0] s;
        s = SEED;
        for (int i = 0; i < T; i++) begin
            if (i < NC) begin
                case (i)
                    0: begin va[i] = 64'd0; vb[i] = 64'd0; end
                    1: begin va[i] = '1; vb[i] = 64'd1; end
                    2: begin va[i] = '1; vb[i] = '1; end
                    default: begin
                        va[i] = 64'h5555_5555_5555_5555;
                        vb[i] = 64'hAAAA_AAAA_AAAA_AAAA;
                    end
                endcase
            end else begin
                va[i] = s;
                vb[i] = {s[31:0], s[63:32]};
                s = xs_step(s);
            end
            vs[i] = {1'b0, va[i]} + {1'b0, vb[i]};
        end
    endtask

    // Expected verdict for a wrapper fault; mode 2 assumes a/b still hold the previous run's last vector.
    task automatic model_expect(input int md, input int k, output logic ep, output int ee,
                                output logic [31:0] ef);
        logic [64:0] got;
        ee = 0;
        ef = '1;
        for (int i = 0; i < T; i++) begin
            if (md == 2) got = (i == 0) ? vs[T-1] : vs[i-1];
            else got = vs[i];
            if (md == 1) got[k] = 1'b0;
            if (got != vs[i]) begin
                ee++;
                if (ef == '1) ef = i;
            end
        end
        ep = (ee == 0);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_pass"}, pass, 0);
        chk({nm, "_a"}, a, 0);
        chk({nm, "_b"}, b, 0);
        chk({nm, "_err"}, err_count, 0);
        chk({nm, "_first"}, first_fail_idx, 64'hFFFF_FFFF);
    endtask

    // Entered at the negedge right after the launch edge; returns at the negedge where busy fell.
    task automatic observe(input string nm, input logic ep, input int ee, input logic [31:0] ef);
        int cycles = 0;
        int bad = 0;
        while (busy && cycles < 500) begin
            if (cycles < T && (a !== va[cycles][W-1:0] || b !== vb[cycles][W-1:0])) bad++;
            cycles++;
            @(negedge clk);
        end
        chk({nm, "_ab_seq_bad"}, bad, 0);
        chk({nm, "_busy_cycles"}, cycles, T + L + 1);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_pass"}, pass, ep);
        chk({nm, "_err"}, err_count, ee);
        chk({nm, "_first"}, first_fail_idx, ef);
    endtask

    task automatic launch(input string nm, input logic ep, input int ee, input logic [31:0] ef);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        observe(nm, ep, ee, ef);
    endtask

    typedef struct {
        string       name;
        int          md;
        int          k;
        logic        ep;
        int          ee;
        logic [31:0] ef;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic        ep;
        int          ee;
        logic [31:0] ef;
        int          wait_n;

        build_model();
        tbl[0] = '{name: "ideal", md: 0, k: 0, ep: 1'b0, ee: 0, ef: '0};
        tbl[1] = '{name: "stuck5", md: 1, k: 5, ep: 1'b0, ee: 0, ef: '0};
        tbl[2] = '{name: "stuck_rand", md: 1, k: int'($urandom_range(0, 64)), ep: 1'b0, ee: 0,
                   ef: '0};
        tbl[3] = '{name: "extra_stage", md: 2, k: 0, ep: 1'b0, ee: 0, ef: '0};
        for (int i = 0; i < 4; i++) begin
            model_expect(tbl[i].md, tbl[i].k, ep, ee, ef);
            tbl[i].ep = ep;
            tbl[i].ee = ee;
            tbl[i].ef = ef;
        end

        #2 rst_n = 1'b0;
        #1 chk_reset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].md;
            bitk = tbl[i].k;
            launch(tbl[i].name, tbl[i].ep, tbl[i].ee, tbl[i].ef);
        end

        // Asynchronous reset in the middle of a run
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_n = int'($urandom_range(1, 8));
        repeat (wait_n) @(negedge clk);
        chk("midrun_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("midrun");
        @(negedge clk);
        rst_n = 1'b1;
        launch("after_reset", 1'b1, 0, 32'hFFFF_FFFF);

        // start held high through a failing run, then relaunch from DONE with a clean wrapper
        mode = 1;
        bitk = 5;
        model_expect(1, 5, ep, ee, ef);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        observe("held_start", ep, ee, ef);
        mode = 0;
        @(negedge clk);
        start = 1'b0;
        chk("relaunch_busy", busy, 1);
        observe("relaunch", 1'b1, 0, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
